// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - compares a retired CPU writeback stream against a preloaded expected trace
module wb_trace_checker #(
  parameter int DEPTH   = 64,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            start,
  input  logic [IW:0]     exp_count,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [IW-1:0]   ld_addr,
  input  logic [4:0]      ld_waddr,
  input  logic [XLEN-1:0] ld_wdata,
  input  logic            ld_write,
  input  logic [2:0]      ld_mask,
  input  logic            retire_valid,
  input  logic [4:0]      reg_waddr,
  input  logic [XLEN-1:0] reg_wdata,
  input  logic            reg_write,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [IW:0]     match_count,
  output logic [IW-1:0]   fail_index,
  output logic [3:0]      fail_field,
  output logic [XLEN-1:0] fail_data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0]   DEPTH_C      = (IW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t state, state_nx;

  // Expected trace storage; deliberately not reset so contents survive clear
  logic [4:0]      mem_waddr [DEPTH];
  logic [XLEN-1:0] mem_wdata [DEPTH];
  logic            mem_write [DEPTH];
  logic [2:0]      mem_mask  [DEPTH];

  logic [IW:0]   cnt;
  logic [IW-1:0] idx;
  logic [TW-1:0] idle_cnt;
  logic [IW:0]   start_cnt;
  logic [2:0]    mis;
  logic          last;
  logic          timeout_hit;
  logic          load_fire;

  assign load_fire   = ld_valid && (state == S_IDLE);
  assign start_cnt   = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
  // Address and data are compared even when the CPU did not write; the mask alone decides
  assign mis         = mem_mask[idx] & {mem_write[idx] != reg_write,
                                        mem_wdata[idx] != reg_wdata,
                                        mem_waddr[idx] != reg_waddr};
  assign last        = ({1'b0, idx} == (cnt - (IW + 1)'(1)));
  assign timeout_hit = (idle_cnt == TIMEOUT_LAST);

  // Trace memory write port, open only while idle
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_waddr[ld_addr] <= ld_waddr;
      mem_wdata[ld_addr] <= ld_wdata;
      mem_write[ld_addr] <= ld_write;
      mem_mask[ld_addr]  <= ld_mask;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; clear overrides everything, pass/fail are sticky otherwise
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = (start_cnt == '0) ? S_PASS : S_RUN;
      S_RUN: begin
        if (retire_valid) begin
          if (mis != 3'b000) state_nx = S_FAIL;
          else if (last)     state_nx = S_PASS;
        end else if (timeout_hit) begin
          state_nx = S_FAIL;
        end
      end
      default: state_nx = state;
    endcase
    if (clear) state_nx = S_IDLE;
  end

  // Status outputs decoded from the registered state
  always_comb begin
    ld_ready = rst && (state == S_IDLE);
    busy     = (state == S_RUN);
    done     = (state == S_PASS) || (state == S_FAIL);
    pass     = (state == S_PASS);
    fail     = (state == S_FAIL);
  end

  // Run bookkeeping: entry index, idle watchdog, match count and failure capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      idx         <= '0;
      idle_cnt    <= '0;
      match_count <= '0;
      fail_index  <= '0;
      fail_field  <= '0;
      fail_data   <= '0;
    end else if (clear) begin
      cnt         <= '0;
      idx         <= '0;
      idle_cnt    <= '0;
      match_count <= '0;
      fail_index  <= '0;
      fail_field  <= '0;
      fail_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt         <= start_cnt;
            idx         <= '0;
            idle_cnt    <= '0;
            match_count <= '0;
            fail_index  <= '0;
            fail_field  <= '0;
            fail_data   <= '0;
          end
        end
        S_RUN: begin
          if (retire_valid) begin
            idle_cnt <= '0;
            if (mis != 3'b000) begin
              fail_index <= idx;
              fail_field <= {1'b0, mis};
              fail_data  <= reg_wdata;
            end else begin
              match_count <= match_count + (IW + 1)'(1);
              idx         <= idx + IW'(1);
            end
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
            if (timeout_hit) begin
              fail_index <= idx;
              fail_field <= 4'b1000;
              fail_data  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb/tb_wb_trace_checker.sv - scoreboard bench for wb_trace_checker
module tb_wb_trace_checker;

  localparam int DEPTH   = 8;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam int IW      = $clog2(DEPTH);

  logic            clk;
  logic            rst;
  logic            clear;
  logic            start;
  logic [IW:0]     exp_count;
  logic            ld_valid;
  logic            ld_ready;
  logic [IW-1:0]   ld_addr;
  logic [4:0]      ld_waddr;
  logic [XLEN-1:0] ld_wdata;
  logic            ld_write;
  logic [2:0]      ld_mask;
  logic            retire_valid;
  logic [4:0]      reg_waddr;
  logic [XLEN-1:0] reg_wdata;
  logic            reg_write;
  logic            busy, done, pass, fail;
  logic [IW:0]     match_count;
  logic [IW-1:0]   fail_index;
  logic [3:0]      fail_field;
  logic [XLEN-1:0] fail_data;

  wb_trace_checker #(.DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .exp_count(exp_count),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_waddr(ld_waddr),
    .ld_wdata(ld_wdata), .ld_write(ld_write), .ld_mask(ld_mask),
    .retire_valid(retire_valid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_write(reg_write), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .match_count(match_count), .fail_index(fail_index), .fail_field(fail_field),
    .fail_data(fail_data)
  );

  typedef struct {
    logic            p;
    logic [IW:0]     mc;
    logic [IW-1:0]   fi;
    logic [3:0]      ff;
    logic [XLEN-1:0] fd;
    int              at;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic done_q   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: each rising edge of done retires one scoreboard entry
  always @(negedge clk) begin
    if (rst && done && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pass", pass, e.p);
        chk("sb_fail", fail, !e.p);
        chk("sb_match_count", match_count, e.mc);
        chk("sb_fail_index", fail_index, e.fi);
        chk("sb_fail_field", fail_field, e.ff);
        chk("sb_fail_data", fail_data, e.fd);
        chk("sb_done_cycle", cyc, e.at);
      end
    end
    done_q = rst && done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [4:0] wa, input logic [XLEN-1:0] wd,
                      input logic w, input logic [2:0] m);
    ld_valid = 1'b1; ld_addr = IW'(a); ld_waddr = wa; ld_wdata = wd; ld_write = w; ld_mask = m;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic start_run(input int n, output int at);
    start = 1'b1; exp_count = (IW + 1)'(n);
    tick();
    at = cyc;
    start = 1'b0;
  endtask

  task automatic retire(input logic [4:0] wa, input logic [XLEN-1:0] wd, input logic w,
                        output int at);
    retire_valid = 1'b1; reg_waddr = wa; reg_wdata = wd; reg_write = w;
    tick();
    at = cyc;
    retire_valid = 1'b0;
  endtask

  task automatic push(input logic p, input int mc, input int fi, input logic [3:0] ff,
                      input logic [XLEN-1:0] fd, input int at);
    exp_t e;
    e.p = p; e.mc = (IW + 1)'(mc); e.fi = IW'(fi); e.ff = ff; e.fd = fd; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int limit);
    for (int i = 0; i < limit && !done; i++) tick();
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1; clear = 1'b0; start = 1'b0; exp_count = '0; ld_valid = 1'b0;
    ld_addr = '0; ld_waddr = '0; ld_wdata = '0; ld_write = 1'b0; ld_mask = '0;
    retire_valid = 1'b0; reg_waddr = '0; reg_wdata = '0; reg_write = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match_count", match_count, 0);
    chk("rst_fail_field", fail_field, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle_ld_ready", ld_ready, 1);
    chk("idle_busy", busy, 0);

    // Basic three-entry trace, all fields checked
    load(0, 5'd1, 32'h3E8, 1'b1, 3'b111);
    load(1, 5'd2, 32'h3C0, 1'b1, 3'b111);
    load(2, 5'd8, 32'h8,   1'b0, 3'b111);
    start_run(3, t);
    chk("run_busy", busy, 1);
    chk("run_ld_ready", ld_ready, 0);
    retire(5'd1, 32'h3E8, 1'b1, t);
    retire(5'd2, 32'h3C0, 1'b1, t);
    retire(5'd8, 32'h8,   1'b0, t);
    push(1'b1, 3, 0, 4'b0000, 32'h0, t);
    wait_done("basic", 4);

    // Clear wins over start in PASS; rerun from retained memory
    clear = 1'b1; start = 1'b1; exp_count = 4'd3;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("clr_done", done, 0);
    chk("clr_busy", busy, 0);
    chk("clr_match_count", match_count, 0);
    chk("clr_ld_ready", ld_ready, 1);
    start_run(3, t);
    retire(5'd1, 32'h3E8, 1'b1, t);
    retire(5'd2, 32'h3C0, 1'b1, t);
    retire(5'd8, 32'h8,   1'b0, t);
    push(1'b1, 3, 0, 4'b0000, 32'h0, t);
    wait_done("rerun", 4);
    do_clear();

    // Data mismatch on second retire; later retires ignored
    start_run(3, t);
    retire(5'd1, 32'h3E8, 1'b1, t);
    retire(5'd2, 32'h3C1, 1'b1, t);
    push(1'b0, 1, 1, 4'b0010, 32'h3C1, t);
    wait_done("wdata_mis", 4);
    retire(5'd8, 32'h8, 1'b0, t);
    chk("sticky_fail", fail, 1);
    chk("sticky_match_count", match_count, 1);
    do_clear();

    // Write and address mismatch, address compared with reg_write low
    start_run(3, t);
    retire(5'd3, 32'h3E8, 1'b0, t);
    push(1'b0, 0, 0, 4'b0101, 32'h3E8, t);
    wait_done("waddr_write_mis", 4);
    do_clear();

    // Partial mask on entry 2 and zero mask on entry 3
    load(2, 5'd8, 32'h8, 1'b0, 3'b100);
    load(3, 5'd0, 32'h0, 1'b0, 3'b000);
    start_run(4, t);
    retire(5'd1, 32'h3E8, 1'b1, t);
    retire(5'd2, 32'h3C0, 1'b1, t);
    retire(5'd9, 32'h55, 1'b0, t);
    retire(5'd17, 32'hDEAD, 1'b1, t);
    push(1'b1, 4, 0, 4'b0000, 32'h0, t);
    wait_done("mask", 4);
    do_clear();

    // Watchdog with no retirements
    start_run(2, t);
    push(1'b0, 0, 0, 4'b1000, 32'h0, t + TIMEOUT);
    wait_done("timeout0", TIMEOUT + 4);
    do_clear();

    // Watchdog restarts after a match
    start_run(2, t);
    retire(5'd1, 32'h3E8, 1'b1, t);
    push(1'b0, 1, 1, 4'b1000, 32'h0, t + TIMEOUT);
    wait_done("timeout1", TIMEOUT + 4);
    do_clear();

    // Zero-length run
    start_run(0, t);
    push(1'b1, 0, 0, 4'b0000, 32'h0, t);
    wait_done("zero", 4);
    do_clear();

    // Over-length request is clamped to DEPTH
    for (int i = 0; i < DEPTH; i++)
      load(i, 5'(i + 1), 32'h100 + 32'(i) * 32'h11, i[0], 3'b111);
    start_run(DEPTH + 5, t);
    for (int i = 0; i < DEPTH; i++)
      retire(5'(i + 1), 32'h100 + 32'(i) * 32'h11, i[0], t);
    push(1'b1, DEPTH, 0, 4'b0000, 32'h0, t);
    wait_done("clamp", 4);
    do_clear();

    // Asynchronous reset in the middle of a run
    start_run(3, t);
    retire(5'd1, 32'h100, 1'b0, t);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_match_count", match_count, 0);
    chk("arst_ld_ready", ld_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_idle_ld_ready", ld_ready, 1);
    chk("arst_idle_busy", busy, 0);

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
